// File: rtl/fuzz_report_collector.sv
// Collects status reports written by a fuzzing satellite into a timestamped
// first-word-fall-through FIFO and keeps saturating per-class event counters.
module fuzz_report_collector #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 8,
    parameter int                    TS_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] REPORT_ADDR = 32'h8000_0000,
    parameter int                    COOLDOWN    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sat_req_i,
    input  logic                        sat_we_i,
    input  logic [ADDR_WIDTH-1:0]       sat_addr_write_i,
    input  logic [DATA_WIDTH-1:0]       sat_wdata_i,
    output logic                        sat_write_done_o,
    input  logic                        host_pop_i,
    input  logic                        host_clr_i,
    output logic                        rpt_valid_o,
    output logic [DATA_WIDTH-1:0]       rpt_data_o,
    output logic [TS_WIDTH-1:0]         rpt_ts_o,
    output logic [$clog2(DEPTH):0]      fifo_count_o,
    output logic [15:0]                 crash_cnt_o,
    output logic [15:0]                 hang_cnt_o,
    output logic [15:0]                 ovf_cnt_o,
    output logic [15:0]                 mism_cnt_o,
    output logic [15:0]                 drop_cnt_o,
    output logic [15:0]                 badaddr_cnt_o,
    output logic                        irq_o
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CLW  = $clog2(COOLDOWN + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE,
        S_COOL
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  match_q, match_d;
    logic [TS_WIDTH-1:0]   tsLatch_q, tsLatch_d;
    logic [CLW-1:0]        cool_q, cool_d;
    logic [TS_WIDTH-1:0]   ts_q;

    logic [DATA_WIDTH-1:0] memData_q [DEPTH];
    logic [TS_WIDTH-1:0]   memTs_q   [DEPTH];
    logic [PW-1:0]         wrPtr_q, rdPtr_q;
    logic [CNTW-1:0]       count_q;

    logic [15:0] crashCnt_q, hangCnt_q, ovfCnt_q, mismCnt_q, dropCnt_q, badAddrCnt_q;

    logic        capture, fifoFull, popEn, pushEn, dropEv, badEv;
    logic [15:0] tag;

    function automatic logic [15:0] satInc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            match_q   <= 1'b0;
            tsLatch_q <= '0;
            cool_q    <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            match_q   <= match_d;
            tsLatch_q <= tsLatch_d;
            cool_q    <= cool_d;
        end
    end

    // The cooldown state lasts exactly COOLDOWN cycles, giving a COOLDOWN+3 cycle report period.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        match_d   = match_q;
        tsLatch_d = tsLatch_q;
        cool_d    = cool_q;
        case (state_q)
            S_IDLE: begin
                if (sat_req_i && sat_we_i) begin
                    data_d    = sat_wdata_i;
                    match_d   = (sat_addr_write_i == REPORT_ADDR);
                    tsLatch_d = ts_q;
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (COOLDOWN == 0) begin
                    state_d = S_IDLE;
                end else begin
                    cool_d  = CLW'(COOLDOWN);
                    state_d = S_COOL;
                end
            end
            S_COOL: begin
                if (cool_q <= CLW'(1)) begin
                    cool_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    cool_d = cool_q - CLW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sat_write_done_o = (state_q == S_DONE);

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign capture  = (state_q == S_CAPTURE);
    assign fifoFull = (count_q == CNTW'(DEPTH));
    assign popEn    = host_pop_i && (count_q != '0);
    assign pushEn   = capture && match_q && (!fifoFull || popEn);
    assign dropEv   = capture && match_q && fifoFull && !popEn;
    assign badEv    = capture && !match_q;
    assign tag      = data_q[31:16];

    always_ff @(posedge clk) begin
        if (pushEn && !host_clr_i) begin
            memData_q[wrPtr_q] <= data_q;
            memTs_q[wrPtr_q]   <= tsLatch_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            crashCnt_q   <= '0;
            hangCnt_q    <= '0;
            ovfCnt_q     <= '0;
            mismCnt_q    <= '0;
            dropCnt_q    <= '0;
            badAddrCnt_q <= '0;
        end else if (host_clr_i) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            crashCnt_q   <= '0;
            hangCnt_q    <= '0;
            ovfCnt_q     <= '0;
            mismCnt_q    <= '0;
            dropCnt_q    <= '0;
            badAddrCnt_q <= '0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            if (pushEn && !popEn) begin
                count_q <= count_q + CNTW'(1);
            end else if (!pushEn && popEn) begin
                count_q <= count_q - CNTW'(1);
            end
            crashCnt_q   <= satInc(crashCnt_q, pushEn && (tag == 16'hDEAD));
            hangCnt_q    <= satInc(hangCnt_q,  pushEn && (tag == 16'hBEEF));
            ovfCnt_q     <= satInc(ovfCnt_q,   pushEn && (tag == 16'hC0DE));
            mismCnt_q    <= satInc(mismCnt_q,  pushEn && (tag == 16'hFFFF));
            dropCnt_q    <= satInc(dropCnt_q, dropEv);
            badAddrCnt_q <= satInc(badAddrCnt_q, badEv);
        end
    end

    assign rpt_valid_o   = (count_q != '0);
    assign rpt_data_o    = rpt_valid_o ? memData_q[rdPtr_q] : '0;
    assign rpt_ts_o      = rpt_valid_o ? memTs_q[rdPtr_q] : '0;
    assign fifo_count_o  = count_q;
    assign crash_cnt_o   = crashCnt_q;
    assign hang_cnt_o    = hangCnt_q;
    assign ovf_cnt_o     = ovfCnt_q;
    assign mism_cnt_o    = mismCnt_q;
    assign drop_cnt_o    = dropCnt_q;
    assign badaddr_cnt_o = badAddrCnt_q;
    assign irq_o         = rpt_valid_o || (dropCnt_q != 16'd0);

endmodule

// File: tb/tb_fuzz_report_collector.sv
// Scoreboard bench for fuzz_report_collector: expected reports are queued at
// stimulus time and compared by a monitor whenever the host pops the FIFO head.
module tb_fuzz_report_collector;

    localparam logic [31:0] RPT = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] ts;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        satReq = 1'b0;
    logic        satWe = 1'b0;
    logic [31:0] satAddr = '0;
    logic [31:0] satData = '0;
    logic        hostPop = 1'b0;
    logic        hostClr = 1'b0;
    logic        doneO;
    logic        rptValid;
    logic [31:0] rptData;
    logic [15:0] rptTs;
    logic [3:0]  fifoCount;
    logic [15:0] crashCnt, hangCnt, ovfCnt, mismCnt, dropCnt, badAddrCnt;
    logic        irq;

    int   passCnt = 0;
    int   checkCnt = 0;
    int   doneCount = 0;
    int   lastDone = -1;
    bit   spacingOn = 1'b0;
    int   cycNo = 0;
    logic [15:0] tbTs;
    exp_t expQ[$];

    fuzz_report_collector dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sat_req_i        (satReq),
        .sat_we_i         (satWe),
        .sat_addr_write_i (satAddr),
        .sat_wdata_i      (satData),
        .sat_write_done_o (doneO),
        .host_pop_i       (hostPop),
        .host_clr_i       (hostClr),
        .rpt_valid_o      (rptValid),
        .rpt_data_o       (rptData),
        .rpt_ts_o         (rptTs),
        .fifo_count_o     (fifoCount),
        .crash_cnt_o      (crashCnt),
        .hang_cnt_o       (hangCnt),
        .ovf_cnt_o        (ovfCnt),
        .mism_cnt_o       (mismCnt),
        .drop_cnt_o       (dropCnt),
        .badaddr_cnt_o    (badAddrCnt),
        .irq_o            (irq)
    );

    always #5 clk = ~clk;

    // Reference free-running timestamp, used to predict the stamp of each report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tbTs <= '0;
        else        tbTs <= tbTs + 16'd1;
    end

    always @(posedge clk) cycNo <= cycNo + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCnt++;
        if (actual === expected) passCnt++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitN(input int n);
        repeat (n) tick();
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input int hold, input bit expectPush);
        if (expectPush) expQ.push_back({data, tbTs});
        satReq  = 1'b1;
        satWe   = 1'b1;
        satAddr = addr;
        satData = data;
        waitN(hold);
        satReq  = 1'b0;
        satWe   = 1'b0;
    endtask

    task automatic popAll();
        int guard = 0;
        while (rptValid && guard < 20) begin
            hostPop = 1'b1;
            tick();
            hostPop = 1'b0;
            guard++;
        end
        settle();
        checkOutput("drainEmpty", {31'd0, rptValid}, 32'd0);
        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        tick();
    endtask

    // Monitor: compares the head against the scoreboard on every accepted pop.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && hostPop && rptValid) begin
                if (expQ.size() == 0) begin
                    checkCnt++;
                    $display("[TB] FAIL unexpectedPop: got data %h, expected no report", rptData);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rptData", rptData, e.data);
                    checkOutput("rptTs", {16'd0, rptTs}, {16'd0, e.ts});
                end
            end
            if (rst_n && doneO) begin
                doneCount++;
                if (spacingOn && lastDone >= 0) checkOutput("donePeriod", cycNo - lastDone, 32'd7);
                lastDone = cycNo;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int d0;
        logic [15:0] t0;
        #2 rst_n = 1'b0;
        waitN(3);
        settle();
        checkOutput("rstValid", {31'd0, rptValid}, 32'd0);
        checkOutput("rstCount", {28'd0, fifoCount}, 32'd0);
        checkOutput("rstDone", {31'd0, doneO}, 32'd0);
        checkOutput("rstIrq", {31'd0, irq}, 32'd0);
        checkOutput("rstData", rptData, 32'd0);
        checkOutput("rstCrash", {16'd0, crashCnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        waitN(2);

        $display("[TB] single crash report");
        applyStimulus(RPT, 32'hDEAD_0001, 1, 1'b1);
        settle();
        checkOutput("doneInCapture", {31'd0, doneO}, 32'd0);
        checkOutput("validBeforePush", {31'd0, rptValid}, 32'd0);
        tick();
        settle();
        checkOutput("donePulse", {31'd0, doneO}, 32'd1);
        checkOutput("validAfterPush", {31'd0, rptValid}, 32'd1);
        checkOutput("headData", rptData, 32'hDEAD_0001);
        checkOutput("crashCnt1", {16'd0, crashCnt}, 32'd1);
        checkOutput("irqValid", {31'd0, irq}, 32'd1);
        checkOutput("count1", {28'd0, fifoCount}, 32'd1);
        tick();
        settle();
        checkOutput("doneOneCycle", {31'd0, doneO}, 32'd0);
        tick();
        popAll();
        settle();
        checkOutput("irqCleared", {31'd0, irq}, 32'd0);
        tick();

        $display("[TB] persistent request");
        waitN(10);
        spacingOn = 1'b1;
        lastDone  = -1;
        d0 = doneCount;
        t0 = tbTs;
        for (int k = 0; k < 6; k++) expQ.push_back({32'hBEEF_0002, 16'(t0 + 16'(7 * k))});
        applyStimulus(RPT, 32'hBEEF_0002, 40, 1'b0);
        waitN(6);
        settle();
        spacingOn = 1'b0;
        checkOutput("heldDoneCount", doneCount - d0, 32'd6);
        checkOutput("hangCnt6", {16'd0, hangCnt}, 32'd6);
        checkOutput("heldCount", {28'd0, fifoCount}, 32'd6);
        tick();
        popAll();

        $display("[TB] overflow with ten reports");
        waitN(4);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(RPT, 32'hC0DE_0000 | 32'(i), 1, (i < 8));
            waitN(8);
        end
        settle();
        checkOutput("fullCount", {28'd0, fifoCount}, 32'd8);
        checkOutput("dropCnt2", {16'd0, dropCnt}, 32'd2);
        checkOutput("ovfCnt8", {16'd0, ovfCnt}, 32'd8);
        tick();
        popAll();
        settle();
        checkOutput("irqFromDrop", {31'd0, irq}, 32'd1);
        tick();
        hostClr = 1'b1;
        tick();
        hostClr = 1'b0;
        settle();
        checkOutput("clrDrop", {16'd0, dropCnt}, 32'd0);
        checkOutput("clrOvf", {16'd0, ovfCnt}, 32'd0);
        checkOutput("clrHang", {16'd0, hangCnt}, 32'd0);
        checkOutput("clrCrash", {16'd0, crashCnt}, 32'd0);
        checkOutput("clrIrq", {31'd0, irq}, 32'd0);
        tick();

        $display("[TB] push and pop together while full");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(RPT, 32'h0000_1000 + 32'(i), 1, 1'b1);
            waitN(8);
        end
        applyStimulus(RPT, 32'hFFFF_0009, 1, 1'b1);
        hostPop = 1'b1;
        tick();
        hostPop = 1'b0;
        settle();
        checkOutput("fullPopCount", {28'd0, fifoCount}, 32'd8);
        checkOutput("fullPopDrop", {16'd0, dropCnt}, 32'd0);
        checkOutput("mismCnt1", {16'd0, mismCnt}, 32'd1);
        tick();
        waitN(6);
        popAll();

        $display("[TB] bad address and clear during push");
        d0 = doneCount;
        applyStimulus(32'h8000_0004, 32'hDEAD_0005, 1, 1'b0);
        waitN(8);
        settle();
        checkOutput("badDone", doneCount - d0, 32'd1);
        checkOutput("badCount", {28'd0, fifoCount}, 32'd0);
        checkOutput("badAddrCnt1", {16'd0, badAddrCnt}, 32'd1);
        checkOutput("badCrash", {16'd0, crashCnt}, 32'd0);
        tick();
        d0 = doneCount;
        applyStimulus(RPT, 32'hDEAD_0006, 1, 1'b0);
        hostClr = 1'b1;
        tick();
        hostClr = 1'b0;
        waitN(6);
        settle();
        checkOutput("clrPushCount", {28'd0, fifoCount}, 32'd0);
        checkOutput("clrPushValid", {31'd0, rptValid}, 32'd0);
        checkOutput("clrPushBad", {16'd0, badAddrCnt}, 32'd0);
        checkOutput("clrPushCrash", {16'd0, crashCnt}, 32'd0);
        checkOutput("clrPushDone", doneCount - d0, 32'd1);
        tick();

        $display("[TB] reset during capture");
        d0 = doneCount;
        applyStimulus(RPT, 32'hDEAD_0007, 1, 1'b0);
        rst_n = 1'b0;
        settle();
        checkOutput("midRstDone", {31'd0, doneO}, 32'd0);
        checkOutput("midRstValid", {31'd0, rptValid}, 32'd0);
        checkOutput("midRstCount", {28'd0, fifoCount}, 32'd0);
        checkOutput("midRstIrq", {31'd0, irq}, 32'd0);
        checkOutput("midRstCrash", {16'd0, crashCnt}, 32'd0);
        checkOutput("midRstTs", {16'd0, rptTs}, 32'd0);
        tick();
        rst_n = 1'b1;
        waitN(12);
        settle();
        checkOutput("noDoneAfterRst", doneCount - d0, 32'd0);
        checkOutput("noPushAfterRst", {28'd0, fifoCount}, 32'd0);
        tick();
        applyStimulus(RPT, 32'hDEAD_0008, 1, 1'b1);
        waitN(8);
        settle();
        checkOutput("postRstCrash", {16'd0, crashCnt}, 32'd1);
        tick();
        popAll();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
